// File: rtl/jtag_tap_multireg.sv
// IEEE 1149.1 TAP controller with IDCODE, BYPASS, interrupt-status and NUM_REGS
// CTAP data registers. Scans become single-cycle write strobes in the jtag_clk domain.
module jtag_tap_multireg #(
    parameter int unsigned          DATA_WIDTH  = 64,
    parameter int unsigned          IR_WIDTH    = 6,
    parameter int unsigned          NUM_REGS    = 4,
    parameter int unsigned          SEL_WIDTH   = 2,
    parameter int unsigned          NUM_IRQ     = 1,
    parameter logic [31:0]          IDCODE_VAL  = 32'h0000_0001,
    parameter logic [IR_WIDTH-1:0]  IR_IDCODE   = 6'h01,
    parameter logic [IR_WIDTH-1:0]  IR_REG_BASE = 6'h20,
    parameter logic [IR_WIDTH-1:0]  IR_IRQ      = 6'h30
) (
    input  logic                  jtag_clk,
    input  logic                  jtag_rst_l,
    input  logic                  jtag_modesel,
    input  logic                  jtag_datain,
    output logic                  jtag_dataout,
    output logic                  jtag_dataout_en,
    input  logic [DATA_WIDTH-1:0] ctap_jtag_data,
    input  logic [NUM_IRQ-1:0]    ctap_jtag_irq,
    output logic [DATA_WIDTH-1:0] jtag_ctap_data,
    output logic                  jtag_ctap_reg_wr_en,
    output logic                  jtag_ctap_reg_rd_en,
    output logic [SEL_WIDTH-1:0]  jtag_ctap_reg_sel,
    output logic [3:0]            tap_state
);

    typedef enum logic [3:0] {
        ST_EXIT2_DR   = 4'h0, ST_EXIT1_DR   = 4'h1, ST_SHIFT_DR   = 4'h2, ST_PAUSE_DR   = 4'h3,
        ST_SELECT_IR  = 4'h4, ST_UPDATE_DR  = 4'h5, ST_CAPTURE_DR = 4'h6, ST_SELECT_DR  = 4'h7,
        ST_EXIT2_IR   = 4'h8, ST_EXIT1_IR   = 4'h9, ST_SHIFT_IR   = 4'hA, ST_PAUSE_IR   = 4'hB,
        ST_RUN_IDLE   = 4'hC, ST_UPDATE_IR  = 4'hD, ST_CAPTURE_IR = 4'hE, ST_TLR        = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {DR_BYPASS = 2'd0, DR_IDCODE = 2'd1, DR_REG = 2'd2, DR_IRQ = 2'd3} dr_sel_e;

    tap_state_e             r_state;
    tap_state_e             w_state_next;
    logic [IR_WIDTH-1:0]    r_ir;
    logic [IR_WIDTH-1:0]    r_ir_sr;
    logic [DATA_WIDTH-1:0]  r_dr_sr;
    logic [DATA_WIDTH-1:0]  r_ctap_data;
    logic [SEL_WIDTH-1:0]   r_reg_sel;
    logic                   r_wr_en;
    dr_sel_e                w_dr_sel;
    logic [DATA_WIDTH-1:0]  w_dr_capture;
    logic [DATA_WIDTH-1:0]  w_dr_shift;
    logic                   w_tdo;
    logic                   w_tdo_en;
    logic                   w_rd_en;

    // Opcodes past the last implemented register fall through to BYPASS.
    function automatic logic f_is_reg(input logic [IR_WIDTH-1:0] op);
        logic [IR_WIDTH-1:0] off;
        off = op - IR_REG_BASE;
        return (op >= IR_REG_BASE) && (32'(off) < NUM_REGS);
    endfunction

    // TAP state register
    always_ff @(posedge jtag_clk) begin
        if (!jtag_rst_l) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // 1149.1 next-state decode on TMS
    always_comb begin
        w_state_next = ST_TLR;
        case (r_state)
            ST_TLR:        w_state_next = jtag_modesel ? ST_TLR       : ST_RUN_IDLE;
            ST_RUN_IDLE:   w_state_next = jtag_modesel ? ST_SELECT_DR : ST_RUN_IDLE;
            ST_SELECT_DR:  w_state_next = jtag_modesel ? ST_SELECT_IR : ST_CAPTURE_DR;
            ST_CAPTURE_DR: w_state_next = jtag_modesel ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:   w_state_next = jtag_modesel ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:   w_state_next = jtag_modesel ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:   w_state_next = jtag_modesel ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:   w_state_next = jtag_modesel ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:  w_state_next = jtag_modesel ? ST_SELECT_DR : ST_RUN_IDLE;
            ST_SELECT_IR:  w_state_next = jtag_modesel ? ST_TLR       : ST_CAPTURE_IR;
            ST_CAPTURE_IR: w_state_next = jtag_modesel ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:   w_state_next = jtag_modesel ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:   w_state_next = jtag_modesel ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:   w_state_next = jtag_modesel ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:   w_state_next = jtag_modesel ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:  w_state_next = jtag_modesel ? ST_SELECT_DR : ST_RUN_IDLE;
            default:       w_state_next = ST_TLR;
        endcase
    end

    // State-decoded outputs: TDO, its enable and the CTAP capture strobe
    always_comb begin
        w_tdo    = 1'b0;
        w_tdo_en = 1'b0;
        w_rd_en  = 1'b0;
        case (r_state)
            ST_SHIFT_IR: begin
                w_tdo    = r_ir_sr[0];
                w_tdo_en = 1'b1;
            end
            ST_SHIFT_DR: begin
                w_tdo    = r_dr_sr[0];
                w_tdo_en = 1'b1;
            end
            ST_CAPTURE_DR: w_rd_en = (w_dr_sel == DR_REG);
            default:       w_rd_en = 1'b0;
        endcase
    end

    // Instruction decode to the active DR
    always_comb begin
        if (r_ir == IR_IDCODE) begin
            w_dr_sel = DR_IDCODE;
        end else if (f_is_reg(r_ir)) begin
            w_dr_sel = DR_REG;
        end else if (r_ir == IR_IRQ) begin
            w_dr_sel = DR_IRQ;
        end else begin
            w_dr_sel = DR_BYPASS;
        end
    end

    // Capture value and length-aware shift: TDI enters at bit L-1 of the selected DR
    always_comb begin
        w_dr_shift = {1'b0, r_dr_sr[DATA_WIDTH-1:1]};
        case (w_dr_sel)
            DR_IDCODE: begin
                w_dr_capture   = DATA_WIDTH'(IDCODE_VAL);
                w_dr_shift[31] = jtag_datain;
            end
            DR_REG: begin
                w_dr_capture               = ctap_jtag_data;
                w_dr_shift[DATA_WIDTH-1]   = jtag_datain;
            end
            DR_IRQ: begin
                w_dr_capture             = DATA_WIDTH'(ctap_jtag_irq);
                w_dr_shift[NUM_IRQ-1]    = jtag_datain;
            end
            default: begin
                w_dr_capture  = {DATA_WIDTH{1'b0}};
                w_dr_shift[0] = jtag_datain;
            end
        endcase
    end

    // IR/DR datapath, register select and write strobe
    always_ff @(posedge jtag_clk) begin
        if (!jtag_rst_l) begin
            r_ir        <= IR_IDCODE;
            r_ir_sr     <= {IR_WIDTH{1'b0}};
            r_dr_sr     <= {DATA_WIDTH{1'b0}};
            r_ctap_data <= {DATA_WIDTH{1'b0}};
            r_reg_sel   <= {SEL_WIDTH{1'b0}};
            r_wr_en     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_CAPTURE_IR: r_ir_sr <= IR_WIDTH'(2'b01);
                ST_SHIFT_IR:   r_ir_sr <= {jtag_datain, r_ir_sr[IR_WIDTH-1:1]};
                ST_UPDATE_IR: begin
                    r_ir <= r_ir_sr;
                    if (f_is_reg(r_ir_sr)) begin
                        r_reg_sel <= SEL_WIDTH'(r_ir_sr - IR_REG_BASE);
                    end
                end
                ST_CAPTURE_DR: r_dr_sr <= w_dr_capture;
                ST_SHIFT_DR:   r_dr_sr <= w_dr_shift;
                ST_UPDATE_DR: begin
                    if (w_dr_sel == DR_REG) begin
                        r_ctap_data <= r_dr_sr;
                        r_wr_en     <= 1'b1;
                    end
                end
                default: r_wr_en <= 1'b0;
            endcase
            // Every path into Test-Logic-Reset restores the IDCODE instruction
            if (w_state_next == ST_TLR) begin
                r_ir <= IR_IDCODE;
            end
        end
    end

    assign jtag_dataout        = w_tdo;
    assign jtag_dataout_en     = w_tdo_en;
    assign jtag_ctap_reg_rd_en = w_rd_en;
    assign jtag_ctap_reg_wr_en = r_wr_en;
    assign jtag_ctap_data      = r_ctap_data;
    assign jtag_ctap_reg_sel   = r_reg_sel;
    assign tap_state           = r_state;

endmodule
